// File: rtl/hazard_unit_ms_if.sv
// Hazard unit bundle: ID-stage operand info, downstream writer info,
// branch/clear controls, and the forward/stall/flush/counter results.
interface hazard_unit_ms_if #(
  parameter int REG_BITS   = 5,
  parameter int FWD_STAGES = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int FSEL_W     = $clog2(FWD_STAGES + 1)
);
  logic                             r1_used;
  logic [REG_BITS-1:0]              r1_no;
  logic                             r2_used;
  logic [REG_BITS-1:0]              r2_no;
  logic [FWD_STAGES-1:0]            wr_en;
  logic [FWD_STAGES*REG_BITS-1:0]   wr_no;
  logic [FWD_STAGES-1:0]            not_ready;
  logic                             branch_taken;
  logic                             cnt_clr;
  logic [FSEL_W-1:0]                r1_fwd;
  logic [FSEL_W-1:0]                r2_fwd;
  logic                             stall;
  logic                             flush;
  logic [CNT_WIDTH-1:0]             stall_cnt;
  logic [CNT_WIDTH-1:0]             flush_cnt;
  logic [CNT_WIDTH-1:0]             fwd_cnt;

  // pipeline side: drives operand/writer info, consumes control
  modport master (
    output r1_used, r1_no, r2_used, r2_no, wr_en, wr_no, not_ready,
           branch_taken, cnt_clr,
    input  r1_fwd, r2_fwd, stall, flush, stall_cnt, flush_cnt, fwd_cnt
  );

  // hazard unit side
  modport slave (
    input  r1_used, r1_no, r2_used, r2_no, wr_en, wr_no, not_ready,
           branch_taken, cnt_clr,
    output r1_fwd, r2_fwd, stall, flush, stall_cnt, flush_cnt, fwd_cnt
  );
endinterface

// File: rtl/hazard_unit_ms.sv
// Forwarding / stall / branch-flush control for a pipeline with
// FWD_STAGES downstream writers. Forward selects, stall and flush are
// combinational; a small FSM stretches each accepted branch into a
// FLUSH_CYCLES-long flush burst; three saturating counters track activity.
module hazard_unit_ms #(
  parameter int REG_BITS     = 5,
  parameter int FWD_STAGES   = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32,
  parameter int FSEL_W       = $clog2(FWD_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  hazard_unit_ms_if.slave  bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [2:0]           fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] fwd_cnt_q, fwd_cnt_d;

  logic [FSEL_W-1:0]    win1_s, win2_s;
  logic                 nr1_s, nr2_s;
  logic                 haz1_s, haz2_s;
  logic [FSEL_W-1:0]    r1_fwd_s, r2_fwd_s;
  logic                 accept_s, flush_active_s;
  logic                 stall_s, flush_s;

  // saturating increment: holds at all-ones
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && (v != {CNT_WIDTH{1'b1}})) ? (v + CNT_WIDTH'(1)) : v;
  endfunction

  // youngest matching writer per operand: scan oldest to youngest so the
  // youngest match overwrites any older one
  always_comb begin
    win1_s = '0;
    win2_s = '0;
    nr1_s  = 1'b0;
    nr2_s  = 1'b0;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      win1_s = (bus.r1_used && (bus.r1_no != '0) && bus.wr_en[i] &&
                (bus.wr_no[i*REG_BITS +: REG_BITS] == bus.r1_no)) ? FSEL_W'(i + 1) : win1_s;
      nr1_s  = (bus.r1_used && (bus.r1_no != '0) && bus.wr_en[i] &&
                (bus.wr_no[i*REG_BITS +: REG_BITS] == bus.r1_no)) ? bus.not_ready[i] : nr1_s;
      win2_s = (bus.r2_used && (bus.r2_no != '0) && bus.wr_en[i] &&
                (bus.wr_no[i*REG_BITS +: REG_BITS] == bus.r2_no)) ? FSEL_W'(i + 1) : win2_s;
      nr2_s  = (bus.r2_used && (bus.r2_no != '0) && bus.wr_en[i] &&
                (bus.wr_no[i*REG_BITS +: REG_BITS] == bus.r2_no)) ? bus.not_ready[i] : nr2_s;
    end
  end

  // flush FSM next state: accept a branch only from IDLE, then count down
  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    accept_s       = 1'b0;
    flush_active_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.branch_taken) begin
          accept_s       = 1'b1;
          flush_active_s = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            fcnt_d  = 3'(FLUSH_CYCLES - 2);
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        flush_active_s = 1'b1;
        if (fcnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  // hazard resolution and control outputs; all forced low during reset,
  // and a wrong-path (flushed) instruction never stalls
  always_comb begin
    haz1_s   = (win1_s != '0) && nr1_s;
    haz2_s   = (win2_s != '0) && nr2_s;
    r1_fwd_s = (haz1_s || rst) ? '0 : win1_s;
    r2_fwd_s = (haz2_s || rst) ? '0 : win2_s;
    stall_s  = !rst && (haz1_s || haz2_s) && !flush_active_s;
    flush_s  = !rst && (flush_active_s || stall_s);
  end

  // counter next values; clear wins over increment
  always_comb begin
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      fwd_cnt_d   = '0;
    end else begin
      stall_cnt_d = sat_inc(stall_cnt_q, stall_s);
      flush_cnt_d = sat_inc(flush_cnt_q, accept_s && !rst);
      fwd_cnt_d   = sat_inc(fwd_cnt_q, (r1_fwd_s != '0) || (r2_fwd_s != '0));
    end
  end

  // state and counter registers; reset aborts any burst in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.r1_fwd    = r1_fwd_s;
  assign bus.r2_fwd    = r2_fwd_s;
  assign bus.stall     = stall_s;
  assign bus.flush     = flush_s;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_unit_ms.sv
// Self-checking bench for hazard_unit_ms: constant vector table, directed
// multi-cycle sequences, and randomized cycles against a behavioural model.
module tb_hazard_unit_ms;
  localparam int RB = 5;
  localparam int FS = 3;
  localparam int FC = 3;
  localparam int CW = 4;
  localparam int SW = $clog2(FS + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nmis = 0;

  // model state: remaining flush cycles after the current one, counters
  int m_rem, m_stall_cnt, m_flush_cnt, m_fwd_cnt;

  always #5 clk = ~clk;

  hazard_unit_ms_if #(.REG_BITS(RB), .FWD_STAGES(FS), .CNT_WIDTH(CW)) bus ();
  hazard_unit_ms #(.REG_BITS(RB), .FWD_STAGES(FS), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic          r1_used;
    logic [RB-1:0] r1_no;
    logic          r2_used;
    logic [RB-1:0] r2_no;
    logic [FS-1:0] wr_en;
    logic [RB-1:0] w1, w2, w3;
    logic [FS-1:0] nr;
    int            e_r1, e_r2, e_stall, e_flush;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.r1_used = 1'b0; bus.r1_no = '0; bus.r2_used = 1'b0; bus.r2_no = '0;
    bus.wr_en = '0; bus.wr_no = '0; bus.not_ready = '0;
    bus.branch_taken = 1'b0; bus.cnt_clr = 1'b0;
  endtask

  task automatic set_writers(input logic [FS-1:0] en, input logic [RB-1:0] a,
                             input logic [RB-1:0] b, input logic [RB-1:0] c,
                             input logic [FS-1:0] nr);
    bus.wr_en = en; bus.wr_no = {c, b, a}; bus.not_ready = nr;
  endtask

  // reference: first (youngest) stage whose dest matches decides the operand
  function automatic void model_op(input logic used, input logic [RB-1:0] no,
                                   output int fwd, output bit haz);
    logic [FS*RB-1:0] wn;
    wn  = bus.wr_no;
    fwd = 0;
    haz = 1'b0;
    if (used && no != 0) begin
      for (int s = 1; s <= FS; s++) begin
        if (bus.wr_en[s-1] && wn[s*RB-1 -: RB] == no) begin
          if (bus.not_ready[s-1]) haz = 1'b1;
          else fwd = s;
          break;
        end
      end
    end
  endfunction

  // called at posedge+1 with inputs set: check mid-cycle, then advance model
  task automatic step(input string tag);
    int f1, f2;
    bit h1, h2, acc, fa, st, fl;
    model_op(bus.r1_used, bus.r1_no, f1, h1);
    model_op(bus.r2_used, bus.r2_no, f2, h2);
    acc = (m_rem == 0) && bus.branch_taken;
    fa  = (m_rem > 0) || acc;
    st  = (h1 || h2) && !fa;
    fl  = fa || st;
    #3;
    chk({tag, ".r1_fwd"}, 64'(bus.r1_fwd), 64'(f1));
    chk({tag, ".r2_fwd"}, 64'(bus.r2_fwd), 64'(f2));
    chk({tag, ".stall"}, 64'(bus.stall), 64'(st));
    chk({tag, ".flush"}, 64'(bus.flush), 64'(fl));
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(m_stall_cnt));
    chk({tag, ".flush_cnt"}, 64'(bus.flush_cnt), 64'(m_flush_cnt));
    chk({tag, ".fwd_cnt"}, 64'(bus.fwd_cnt), 64'(m_fwd_cnt));
    @(posedge clk);
    if (bus.cnt_clr) begin
      m_stall_cnt = 0; m_flush_cnt = 0; m_fwd_cnt = 0;
    end else begin
      if (st && m_stall_cnt < CMAX) m_stall_cnt++;
      if (acc && m_flush_cnt < CMAX) m_flush_cnt++;
      if ((f1 != 0 || f2 != 0) && m_fwd_cnt < CMAX) m_fwd_cnt++;
    end
    if (acc) m_rem = FC - 1;
    else if (m_rem > 0) m_rem--;
    #1;
  endtask

  task automatic clear_cycle();
    idle_inputs();
    bus.cnt_clr = 1'b1;
    step("clr");
    bus.cnt_clr = 1'b0;
  endtask

  initial begin
    int flush_seen;
    int saved;

    // stimulus table: forwarding priority and hazard patterns, no branches
    tbl[0] = '{1'b1, 5'd5, 1'b0, 5'd0, 3'b101, 5'd5, 5'd0, 5'd5, 3'b000, 1, 0, 0, 0};
    tbl[1] = '{1'b1, 5'd5, 1'b0, 5'd0, 3'b100, 5'd5, 5'd0, 5'd5, 3'b000, 3, 0, 0, 0};
    tbl[2] = '{1'b1, 5'd0, 1'b0, 5'd0, 3'b111, 5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 0, 0};
    tbl[3] = '{1'b0, 5'd5, 1'b0, 5'd0, 3'b101, 5'd5, 5'd0, 5'd5, 3'b000, 0, 0, 0, 0};
    tbl[4] = '{1'b0, 5'd0, 1'b1, 5'd9, 3'b011, 5'd9, 5'd9, 5'd0, 3'b010, 0, 1, 0, 0};
    tbl[5] = '{1'b0, 5'd0, 1'b1, 5'd9, 3'b011, 5'd9, 5'd9, 5'd0, 3'b001, 0, 0, 1, 1};
    tbl[6] = '{1'b1, 5'd3, 1'b1, 5'd4, 3'b110, 5'd0, 5'd4, 5'd3, 3'b100, 0, 2, 1, 1};
    tbl[7] = '{1'b1, 5'd6, 1'b1, 5'd6, 3'b010, 5'd1, 5'd6, 5'd2, 3'b000, 2, 2, 0, 0};

    m_rem = 0; m_stall_cnt = 0; m_flush_cnt = 0; m_fwd_cnt = 0;
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("reset.r1_fwd", 64'(bus.r1_fwd), 64'd0);
    chk("reset.stall", 64'(bus.stall), 64'd0);
    chk("reset.flush", 64'(bus.flush), 64'd0);
    chk("reset.stall_cnt", 64'(bus.stall_cnt), 64'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      bus.r1_used = tbl[i].r1_used; bus.r1_no = tbl[i].r1_no;
      bus.r2_used = tbl[i].r2_used; bus.r2_no = tbl[i].r2_no;
      set_writers(tbl[i].wr_en, tbl[i].w1, tbl[i].w2, tbl[i].w3, tbl[i].nr);
      #1;
      chk($sformatf("tbl%0d.r1_fwd", i), 64'(bus.r1_fwd), 64'(tbl[i].e_r1));
      chk($sformatf("tbl%0d.r2_fwd", i), 64'(bus.r2_fwd), 64'(tbl[i].e_r2));
      chk($sformatf("tbl%0d.stall", i), 64'(bus.stall), 64'(tbl[i].e_stall));
      chk($sformatf("tbl%0d.flush", i), 64'(bus.flush), 64'(tbl[i].e_flush));
      step("tbl");
    end

    // multi-cycle producer: 3 not-ready cycles then ready
    clear_cycle();
    bus.r2_used = 1'b1; bus.r2_no = 5'd7;
    for (int c = 0; c < 4; c++) begin
      set_writers(3'b001, 5'd7, 5'd0, 5'd0, (c < 3) ? 3'b001 : 3'b000);
      #1;
      chk("mc.stall", 64'(bus.stall), (c < 3) ? 64'd1 : 64'd0);
      chk("mc.flush", 64'(bus.flush), (c < 3) ? 64'd1 : 64'd0);
      chk("mc.r2_fwd", 64'(bus.r2_fwd), (c < 3) ? 64'd0 : 64'd1);
      step("mc");
    end
    idle_inputs();
    #1 chk("mc.stall_cnt", 64'(bus.stall_cnt), 64'd3);
    step("mc");

    // branch burst: exactly FC flush cycles, second branch in burst ignored
    for (int v = 0; v < 2; v++) begin
      clear_cycle();
      flush_seen = 0;
      for (int c = 0; c < 6; c++) begin
        bus.branch_taken = (c == 0) || (v == 1 && c == 1);
        #1 if (bus.flush) flush_seen++;
        step("br");
      end
      chk("br.flush_cycles", 64'(flush_seen), 64'(FC));
      chk("br.flush_cnt", 64'(bus.flush_cnt), 64'd1);
    end

    // branch in the same cycle as a not-ready hazard
    clear_cycle();
    saved = m_stall_cnt;
    bus.r1_used = 1'b1; bus.r1_no = 5'd8;
    set_writers(3'b001, 5'd8, 5'd0, 5'd0, 3'b001);
    bus.branch_taken = 1'b1;
    #1;
    chk("bh.stall", 64'(bus.stall), 64'd0);
    chk("bh.flush", 64'(bus.flush), 64'd1);
    step("bh");
    idle_inputs();
    #1 chk("bh.stall_cnt", 64'(bus.stall_cnt), 64'(saved));
    for (int c = 0; c < 3; c++) step("bh");

    // saturation of fwd_cnt, then clear together with an increment
    clear_cycle();
    bus.r1_used = 1'b1; bus.r1_no = 5'd5;
    set_writers(3'b001, 5'd5, 5'd0, 5'd0, 3'b000);
    for (int c = 0; c < 20; c++) step("sat");
    chk("sat.fwd_cnt", 64'(bus.fwd_cnt), 64'd15);
    bus.cnt_clr = 1'b1;
    step("sat");
    bus.cnt_clr = 1'b0;
    #1 chk("sat.cleared", 64'(bus.fwd_cnt), 64'd0);
    step("sat");

    // asynchronous reset in the middle of a flush burst
    idle_inputs();
    bus.branch_taken = 1'b1;
    step("rst");
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    chk("rst.flush", 64'(bus.flush), 64'd0);
    chk("rst.fwd_cnt", 64'(bus.fwd_cnt), 64'd0);
    chk("rst.flush_cnt", 64'(bus.flush_cnt), 64'd0);
    m_rem = 0; m_stall_cnt = 0; m_flush_cnt = 0; m_fwd_cnt = 0;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("rst.after_flush", 64'(bus.flush), 64'd0);
      step("post");
    end

    // randomized cycles against the model
    for (int c = 0; c < 400; c++) begin
      bus.r1_used = 1'($urandom_range(0, 1)); bus.r1_no = RB'($urandom_range(0, 7));
      bus.r2_used = 1'($urandom_range(0, 1)); bus.r2_no = RB'($urandom_range(0, 7));
      set_writers(FS'($urandom), RB'($urandom_range(0, 7)), RB'($urandom_range(0, 7)),
                  RB'($urandom_range(0, 7)),
                  {($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0});
      bus.branch_taken = ($urandom % 8) == 0;
      bus.cnt_clr = ($urandom % 32) == 0;
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/hazard_unit_ms.md
Name: hazard_unit_ms

Overview:
- Parametrised successor to the two-stage forwarding/stall unit in the pipeline controller.
- Supports FWD_STAGES downstream writer stages with youngest-wins forwarding priority.
- Detects not-ready producers (loads, multi-cycle ops) and asserts stall for as long as they stay not-ready.
- Runs a branch-flush burst of FLUSH_CYCLES cycles via a small FSM, and keeps saturating performance counters.
- Sits between the ID stage and the pipeline-register control signals.

Parameters:
REG_BITS, 5, register number width
FWD_STAGES, 2, number of downstream writer stages (2..4); stage 1 = EX (youngest), stage FWD_STAGES = oldest
FLUSH_CYCLES, 1, cycles flush is held per taken branch (1..7)
CNT_WIDTH, 32, performance counter width
(derived) FSEL_W = clog2(FWD_STAGES+1)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
r1_used  in  1  ID instruction reads operand 1
r1_no  in  REG_BITS  operand 1 register number
r2_used  in  1  ID instruction reads operand 2
r2_no  in  REG_BITS  operand 2 register number
wr_en  in  FWD_STAGES  bit s-1: stage s writes a register
wr_no  in  FWD_STAGES*REG_BITS  stage s dest at bits [s*REG_BITS-1 -: REG_BITS]
not_ready  in  FWD_STAGES  bit s-1: stage s result not yet available
branch_taken  in  1  taken branch resolved in EX this cycle
cnt_clr  in  1  synchronous clear of all counters
r1_fwd  out  FSEL_W  0 = register file, s = forward from stage s
r2_fwd  out  FSEL_W  as r1_fwd
stall  out  1  hold PC and IF/ID
flush  out  1  bubble into ID/EX and IF/ID
stall_cnt  out  CNT_WIDTH  cycles with stall=1
flush_cnt  out  CNT_WIDTH  accepted taken branches
fwd_cnt  out  CNT_WIDTH  cycles with r1_fwd or r2_fwd nonzero

Behaviour:
- Match for operand k at stage s: rk_used & (rk_no!=0) & wr_en[s-1] & (wr_no stage s == rk_no).
- Youngest matching stage (lowest s) wins. Older matches are ignored.
- Hazard on k: the winning stage has not_ready=1. Then rk_fwd=0. Otherwise rk_fwd = winning s, or 0 if there is no match.
- raw_haz = hazard on operand 1 | hazard on operand 2.
- Forward selects and hazard logic are combinational, zero latency.
- Flush FSM states: IDLE, FLUSH. A 3-bit down-counter fcnt is used.
  - IDLE & branch_taken: branch accepted. flush=1 this cycle. If FLUSH_CYCLES>1, load fcnt=FLUSH_CYCLES-2 and go to FLUSH; else stay in IDLE.
  - FLUSH: flush=1. If fcnt==0, go to IDLE; else decrement fcnt.
  - branch_taken while in FLUSH is ignored: the input comes from a bubble, so there is no reload and no count.
- Output equations:
  - flush_active = (state==FLUSH) | (IDLE & branch_taken).
  - stall = raw_haz & ~flush_active. A wrong-path instruction never stalls.
  - flush = flush_active | stall. A stall cycle injects a bubble into ID/EX.
- Multi-cycle producers: stall stays high every cycle while the youngest matching stage keeps not_ready=1. It drops in the first cycle not_ready=0, and rk_fwd=s in that same cycle.
- Counters:
  - stall_cnt increments when stall=1.
  - flush_cnt increments per accepted branch.
  - fwd_cnt increments when any rk_fwd!=0.
  - All three saturate at all-ones. cnt_clr has priority over increment; the value reads 0 the next cycle.
- Reset:
  - While rst=1: state=IDLE, fcnt=0, all counters=0. r1_fwd, r2_fwd, stall and flush are forced to 0.
  - rst asserted mid-burst aborts the burst. After release, flush=0 until a new branch_taken.

Test Plan:
- FWD_STAGES=3. r1_no=5 used; stages 1 and 3 both write r5, all ready -> r1_fwd=1. Drop stage 1 wr_en -> r1_fwd=3. Set r1_no=0 -> r1_fwd=0.
- Stage 1 writes r7 with not_ready=1 for 3 cycles; r2_no=7 used -> stall=1 and flush=1 for 3 cycles with r2_fwd=0. Cycle 4 -> stall=0, r2_fwd=1. stall_cnt=3.
- FLUSH_CYCLES=3: branch_taken for one cycle -> flush=1 for exactly 3 cycles, flush_cnt=1. A second branch_taken in cycle 2 -> ignored, still 3 cycles, flush_cnt=1.
- branch_taken in the same cycle as a not-ready hazard -> stall=0, flush=1, stall_cnt unchanged.
- Preload fwd_cnt to all-ones via a long forwarding run with CNT_WIDTH=4 -> saturates at 15. Assert cnt_clr together with an increment -> 0 next cycle.
- Assert rst asynchronously mid-FLUSH burst -> flush=0 immediately, counters=0. After release with no inputs active -> all outputs 0.
